ecg_diff_sched: RTL and testbench

// - Time-multiplexes one first-difference datapath across N_CH ECG leads.
// - Round-robin arbiter grants one lead sample per cycle; per-lead history registers hold each lead's previous sample.
// - Emits an offset-binary difference tagged with its lead index over a valid/ready output.
// - Sits between the multi-lead ADC front end and the downstream per-lead filter chain.
//

---
 rtl/ecg_diff_sched_pkg.sv | 17 +
 rtl/ecg_diff_sched_rr_arbiter.sv | 38 +++
 rtl/ecg_diff_sched.sv | 120 ++++++++++++
 tb/tb_ecg_diff_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ecg_diff_sched_pkg.sv
// Shared constants and state encoding for the multi-lead ECG first-difference scheduler.
package ecg_diff_sched_pkg;

    localparam int unsigned DATA_INPUT = 8;
    localparam int unsigned ECG_NCH    = 4;

    typedef enum logic [0:0] {
        StIdle,
        StFull
    } state_e;

    // Round-robin successor of a lead index, wrapping n-1 -> 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ecg_diff_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above the pointer wins, else wraps.
module ecg_diff_sched_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any
);

    logic [N-1:0] w_upper;
    logic [N-1:0] w_sel;

    always_comb begin
        w_upper = '0;
        for (int i = 0; i < N; i++) begin
            w_upper[i] = i_req[i] && (i >= int'(i_ptr));
        end
        // Fall back to the full request set when nothing sits at or above the pointer.
        w_sel = (|w_upper) ? w_upper : i_req;

        o_gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                o_gnt_idx = IW'(i);
            end
        end

        o_any = |i_req;
        o_gnt = '0;
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = o_any && (o_gnt_idx == IW'(i));
        end
    end

endmodule

// File: rtl/ecg_diff_sched.sv
// Shares one first-difference datapath across N_CH leads; emits offset-binary deltas tagged
// with the lead index through a single valid/ready output register.
module ecg_diff_sched
    import ecg_diff_sched_pkg::*;
#(
    parameter int unsigned N_CH = ECG_NCH,
    parameter int unsigned DW   = DATA_INPUT,
    parameter int unsigned CH_W = $clog2(N_CH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_CH-1:0]      i_ch_en,
    input  logic                 i_clr,
    input  logic [N_CH-1:0]      i_in_valid,
    input  logic [N_CH*DW-1:0]   i_in_data,
    output logic [N_CH-1:0]      o_in_ready,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [CH_W-1:0]      o_out_ch,
    output logic [DW:0]          o_out_data,
    output logic                 o_busy
);

    localparam logic [DW:0] OFFSET = {1'b1, {DW{1'b0}}};

    state_e          r_state;
    state_e          w_state_next;
    logic [CH_W-1:0] r_ptr;
    logic [DW-1:0]   r_hist [N_CH];
    logic [N_CH-1:0] r_first;
    logic [CH_W-1:0] r_out_ch;
    logic [DW:0]     r_out_data;

    logic            w_free;
    logic            w_grant;
    logic [N_CH-1:0] w_req;
    logic [N_CH-1:0] w_gnt;
    logic [CH_W-1:0] w_gnt_idx;
    logic [DW-1:0]   w_din [N_CH];
    logic [DW-1:0]   w_sel_din;
    logic [DW-1:0]   w_prev;
    logic [DW:0]     w_diff;
    logic [CH_W-1:0] w_ptr_next;

    assign w_free = (r_state == StIdle) || i_out_ready;
    // A clear cycle never grants, so history update and clear cannot collide.
    assign w_req  = (w_free && !i_clr) ? (i_in_valid & i_ch_en) : '0;

    ecg_diff_sched_rr_arbiter #(
        .N  (N_CH),
        .IW (CH_W)
    ) u_arb (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_grant)
    );

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_din[i] = i_in_data[i*DW +: DW];
        end
    end

    assign w_sel_din  = w_din[w_gnt_idx];
    assign w_prev     = r_first[w_gnt_idx] ? '0 : r_hist[w_gnt_idx];
    assign w_diff     = {1'b0, w_sel_din} + OFFSET - {1'b0, w_prev};
    assign w_ptr_next = CH_W'(wrap_inc(int'(w_gnt_idx), N_CH));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_grant) w_state_next = StFull;
            StFull: if (i_out_ready && !w_grant) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_out_valid = (r_state == StFull);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_first    <= '1;
            r_out_ch   <= '0;
            r_out_data <= OFFSET;
            for (int i = 0; i < N_CH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (i_clr) begin
            r_first <= '1;
            for (int i = 0; i < N_CH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_grant) begin
            r_hist[w_gnt_idx]  <= w_sel_din;
            r_first[w_gnt_idx] <= 1'b0;
            r_ptr              <= w_ptr_next;
            r_out_ch           <= w_gnt_idx;
            r_out_data         <= w_diff;
        end
    end

    assign o_in_ready = w_gnt;
    assign o_out_ch   = r_out_ch;
    assign o_out_data = r_out_data;
    assign o_busy     = o_out_valid || (|(i_in_valid & i_ch_en));

endmodule

// File: tb/tb_ecg_diff_sched.sv
// Directed bench for ecg_diff_sched with N_CH=4, DW=8 (offset 256).
module tb_ecg_diff_sched;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ch_en;
    logic            clr;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_ch;
    logic [DW:0]     out_data;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecg_diff_sched #(
        .N_CH (N),
        .DW   (DW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ch_en     (ch_en),
        .i_clr       (clr),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_ch    (out_ch),
        .o_out_data  (out_data),
        .o_busy      (busy)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_data(input int d0, input int d1, input int d2, input int d3);
        in_data = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int exp_ch3 [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int exp_dt3 [8] = '{316, 326, 336, 216, 256, 256, 256, 256};
    int exp_ch5 [5] = '{3, 0, 1, 3, 0};
    int exp_dt5 [5] = '{306, 406, 364, 256, 256};

    initial begin
        rst = 1'b1; ch_en = '0; clr = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 256);
        check("rst_ch", out_ch, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // First sample on lead0, then a second one differenced against it.
        ch_en = 4'hF; out_ready = 1'b1; set_data(100, 0, 0, 0); in_valid = 4'b0001;
        #1;
        check("first_ready", in_ready, 4'b0001);
        check("first_busy", busy, 1);
        tick();
        in_valid = '0;
        check("first_valid", out_valid, 1);
        check("first_ch", out_ch, 0);
        check("first_data", out_data, 356);
        set_data(90, 0, 0, 0); in_valid = 4'b0001;
        tick();
        in_valid = '0;
        check("second_data", out_data, 246);
        tick();
        check("idle_after", out_valid, 0);

        // All leads valid: pointer sits at 1, rotate with no bubbles.
        set_data(50, 60, 70, 80); in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_valid", out_valid, 1);
            check("rr_ch", out_ch, exp_ch3[k]);
            check("rr_data", out_data, exp_dt3[k]);
        end

        // Stall: output held, no grants.
        out_ready = 1'b0; set_data(1, 2, 3, 4);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_ready", in_ready, 0);
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_ch", out_ch, 0);
            check("stall_data", out_data, 256);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", in_ready, 4'b0010);
        tick();
        check("release_ch1", out_ch, 1);
        check("release_d1", out_data, 198);
        tick();
        check("release_ch2", out_ch, 2);
        check("release_d2", out_data, 189);

        // Lead2 disabled: it must be skipped.
        ch_en = 4'b1011; set_data(200, 110, 120, 130);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("mask_ready2", in_ready & 4'b0100, 0);
            tick();
            check("mask_ch", out_ch, exp_ch5[k]);
            check("mask_data", out_data, exp_dt5[k]);
        end
        in_valid = '0;
        tick();
        check("mask_idle", out_valid, 0);
        ch_en = 4'hF;

        // Clear between two lead1 samples; clear cycle blocks the grant.
        set_data(0, 200, 0, 0); in_valid = 4'b0010;
        tick();
        check("clr_pre_ch", out_ch, 1);
        check("clr_pre_data", out_data, 346);
        clr = 1'b1; set_data(0, 50, 0, 0);
        #1;
        check("clr_ready", in_ready, 0);
        tick();
        clr = 1'b0;
        check("clr_no_grant", out_valid, 0);
        #1;
        check("clr_post_ready", in_ready, 4'b0010);
        tick();
        in_valid = '0;
        check("clr_post_ch", out_ch, 1);
        check("clr_post_data", out_data, 306);

        // Asynchronous reset while stalled.
        out_ready = 1'b0; in_valid = 4'b0001; set_data(9, 0, 0, 0);
        tick();
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_valid", out_valid, 0);
        check("async_data", out_data, 256);
        check("async_ch", out_ch, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; set_data(7, 0, 0, 0);
        tick();
        in_valid = '0;
        check("post_rst_valid", out_valid, 1);
        check("post_rst_ch", out_ch, 0);
        check("post_rst_data", out_data, 263);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
